// File: rtl/spawn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spawn_pkg
//  Brief    : Shared state encoding, type codes and speed gating table for
//             the spawn scheduler.
//  Revision : 1.0
// ============================================================================
package spawn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE   = 3'd0;
    localparam state_t c_RUN    = 3'd1;
    localparam state_t c_SPAWN  = 3'd2;
    localparam state_t c_SETTLE = 3'd3;
    localparam state_t c_RETIRE = 3'd4;
    localparam state_t c_HALT   = 3'd5;

    localparam int c_TYPE_NONE = 0;
    localparam int c_RNG_W     = 11;
    localparam int c_X_W       = 11;
    localparam int c_WID_W     = 10;
    localparam int c_GAP_W     = 11;

    // Speed is fixed point with 6 fractional bits; type N unlocks at speed N.0
    localparam int c_SPEED_SCALE = 64;

    localparam logic [15:0] c_MIN_SPEED [16] = '{
        16'(0),                  16'(1 * c_SPEED_SCALE),  16'(2 * c_SPEED_SCALE),
        16'(3 * c_SPEED_SCALE),  16'(4 * c_SPEED_SCALE),  16'(5 * c_SPEED_SCALE),
        16'(6 * c_SPEED_SCALE),  16'(7 * c_SPEED_SCALE),  16'(8 * c_SPEED_SCALE),
        16'(9 * c_SPEED_SCALE),  16'(10 * c_SPEED_SCALE), 16'(11 * c_SPEED_SCALE),
        16'(12 * c_SPEED_SCALE), 16'(13 * c_SPEED_SCALE), 16'(14 * c_SPEED_SCALE),
        16'(15 * c_SPEED_SCALE)
    };

endpackage
`default_nettype wire

// File: rtl/spawn_type_picker.sv
`default_nettype none
// ============================================================================
//  Module   : spawn_type_picker
//  Brief    : Combinational choice of the next object type from the random
//             word, honouring the duplicate-run limit and speed gating.
//  Revision : 1.0
// ============================================================================
module spawn_type_picker
    import spawn_pkg::*;
#(
    parameter int SLOTS      = 7,
    parameter int TYPE_COUNT = 3,
    parameter int MAX_DUP    = 2,
    parameter int SPEED_W    = 15,
    localparam int IW        = $clog2(SLOTS),
    localparam int TW        = $clog2(TYPE_COUNT + 1)
) (
    input  logic [c_RNG_W-1:0]    i_rng,
    input  logic [SPEED_W-1:0]    i_speed,
    input  logic [MAX_DUP*TW-1:0] i_last_types,
    input  logic [IW:0]           i_count,
    output logic                  o_valid,
    output logic [TW-1:0]         o_type
);

    logic [TYPE_COUNT-1:0] w_pass;
    logic [TW-1:0]         w_cand [TYPE_COUNT];
    logic                  w_dup_armed;

    assign w_dup_armed = (i_count >= (IW+1)'(MAX_DUP));

    for (genvar i = 0; i < TYPE_COUNT; i++) begin : g_cand
        logic [11:0] w_sum;
        logic [11:0] w_mod;
        logic        w_same;

        assign w_sum     = {1'b0, i_rng} + 12'(i);
        assign w_mod     = w_sum % 12'(TYPE_COUNT);
        assign w_cand[i] = TW'(w_mod + 12'd1);

        always_comb begin
            w_same = 1'b1;
            for (int k = 0; k < MAX_DUP; k++) begin
                if (i_last_types[k*TW +: TW] != w_cand[i]) begin
                    w_same = 1'b0;
                end
            end
        end

        assign w_pass[i] = !(w_dup_armed && w_same) &&
                           (32'(i_speed) >= 32'(c_MIN_SPEED[4'(w_cand[i])]));
    end

    // Walk from the last candidate down so the lowest passing index wins
    always_comb begin
        o_valid = 1'b0;
        o_type  = '0;
        for (int i = TYPE_COUNT - 1; i >= 0; i--) begin
            if (w_pass[i]) begin
                o_valid = 1'b1;
                o_type  = w_cand[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spawn_scheduler
//  Brief    : Per-frame ring scheduler for scrolling object slots: spawns
//             behind the trailing object and retires expired ones at the front.
//  Revision : 1.0
// ============================================================================
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int SLOTS      = 7,
    parameter int TYPE_COUNT = 3,
    parameter int MAX_DUP    = 2,
    parameter int RETIRE_MAX = 2,
    parameter int GAME_WIDTH = 640,
    parameter int SPEED_W    = 15,
    localparam int IW        = $clog2(SLOTS),
    localparam int TW        = $clog2(TYPE_COUNT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_update,
    input  logic                     i_start,
    input  logic                     i_crash,
    input  logic                     i_enable,
    input  logic [SPEED_W-1:0]       i_speed,
    input  logic [c_RNG_W-1:0]       i_rng_data,
    input  logic [SLOTS-1:0]         i_slot_remove,
    input  logic [SLOTS-1:0]         i_slot_visible,
    input  logic [SLOTS*c_X_W-1:0]   i_slot_x_pos,
    input  logic [SLOTS*c_WID_W-1:0] i_slot_width,
    input  logic [SLOTS*c_GAP_W-1:0] i_slot_gap,
    output logic                     o_slot_update,
    output logic [SLOTS-1:0]         o_slot_start,
    output logic [SLOTS*TW-1:0]      o_slot_type,
    output logic [IW-1:0]            o_front_idx,
    output logic [IW:0]              o_count,
    output logic                     o_full,
    output logic                     o_frame_done
);

    localparam int            RW            = $clog2(RETIRE_MAX + 1);
    localparam logic [IW:0]   c_SLOTS_CNT   = (IW+1)'(SLOTS);
    localparam logic [IW-1:0] c_LAST_IDX    = IW'(SLOTS - 1);
    localparam logic [RW-1:0] c_RETIRE_LAST = RW'(RETIRE_MAX - 1);

    function automatic logic [IW-1:0] incr(input logic [IW-1:0] p);
        return (p == c_LAST_IDX) ? '0 : p + IW'(1);
    endfunction

    // Registered copies of every input: all decisions use a stable sample
    logic                     r_update, r_start, r_crash, r_enable;
    logic [SPEED_W-1:0]       r_speed;
    logic [c_RNG_W-1:0]       r_rng;
    logic [SLOTS-1:0]         r_remove, r_visible;
    logic [SLOTS*c_X_W-1:0]   r_x_pos;
    logic [SLOTS*c_WID_W-1:0] r_width;
    logic [SLOTS*c_GAP_W-1:0] r_gap;

    state_t                   r_state;
    logic [IW-1:0]            r_front, r_back;
    logic [IW:0]              r_count;
    logic [SLOTS-1:0]         r_slot_start;
    logic [TW-1:0]            r_type_arr [SLOTS];
    logic [RW-1:0]            r_retired;

    logic [c_X_W-1:0]         w_x_arr [SLOTS];
    logic [c_WID_W-1:0]       w_w_arr [SLOTS];
    logic [c_GAP_W-1:0]       w_g_arr [SLOTS];
    logic [IW-1:0]            w_last_idx [MAX_DUP];
    logic [MAX_DUP*TW-1:0]    w_last_types;
    logic [IW-1:0]            w_last;
    logic signed [12:0]       w_reach;
    logic                     w_gap_ok, w_empty, w_is_full;
    logic                     w_pick_valid, w_spawn, w_retire, w_retire_last;
    logic [TW-1:0]            w_pick_type;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        assign w_x_arr[s]               = r_x_pos[s*c_X_W +: c_X_W];
        assign w_w_arr[s]               = r_width[s*c_WID_W +: c_WID_W];
        assign w_g_arr[s]               = r_gap[s*c_GAP_W +: c_GAP_W];
        assign o_slot_type[s*TW +: TW]  = r_type_arr[s];
    end

    // Slot k places behind back: (back + SLOTS - 1 - k) mod SLOTS, one subtract
    for (genvar k = 0; k < MAX_DUP; k++) begin : g_last
        localparam logic [IW:0] c_OFF = (IW+1)'(SLOTS - 1 - k);
        logic [IW:0] w_sum;

        assign w_sum         = {1'b0, r_back} + c_OFF;
        assign w_last_idx[k] = (w_sum >= c_SLOTS_CNT) ? IW'(w_sum - c_SLOTS_CNT)
                                                      : w_sum[IW-1:0];
        assign w_last_types[k*TW +: TW] = r_type_arr[w_last_idx[k]];
    end

    assign w_last    = w_last_idx[0];
    assign w_reach   = {{2{w_x_arr[w_last][c_X_W-1]}}, w_x_arr[w_last]}
                     + {3'b000, w_w_arr[w_last]}
                     + {2'b00, w_g_arr[w_last]};
    assign w_gap_ok  = (w_reach < $signed(13'(GAME_WIDTH)));
    assign w_empty   = (r_count == '0);
    assign w_is_full = (r_count == c_SLOTS_CNT);

    spawn_type_picker #(
        .SLOTS      (SLOTS),
        .TYPE_COUNT (TYPE_COUNT),
        .MAX_DUP    (MAX_DUP),
        .SPEED_W    (SPEED_W)
    ) u_picker (
        .i_rng        (r_rng),
        .i_speed      (r_speed),
        .i_last_types (w_last_types),
        .i_count      (r_count),
        .o_valid      (w_pick_valid),
        .o_type       (w_pick_type)
    );

    assign w_spawn       = r_enable && w_pick_valid && !w_is_full &&
                           (w_empty || (r_visible[w_last] && w_gap_ok));
    assign w_retire      = !w_empty && r_remove[r_front];
    assign w_retire_last = (r_retired == c_RETIRE_LAST);

    assign o_slot_update = (r_state == c_SPAWN);
    assign o_frame_done  = (r_state == c_RETIRE) && !r_crash &&
                           (!w_retire || w_retire_last);
    assign o_slot_start  = r_slot_start;
    assign o_front_idx   = r_front;
    assign o_count       = r_count;
    assign o_full        = w_is_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_update     <= 1'b0;
            r_start      <= 1'b0;
            r_crash      <= 1'b0;
            r_enable     <= 1'b0;
            r_speed      <= '0;
            r_rng        <= '0;
            r_remove     <= '0;
            r_visible    <= '0;
            r_x_pos      <= '0;
            r_width      <= '0;
            r_gap        <= '0;
            r_state      <= c_IDLE;
            r_front      <= '0;
            r_back       <= '0;
            r_count      <= '0;
            r_slot_start <= '0;
            r_retired    <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                r_type_arr[s] <= TW'(c_TYPE_NONE);
            end
        end else begin
            r_update  <= i_update;
            r_start   <= i_start;
            r_crash   <= i_crash;
            r_enable  <= i_enable;
            r_speed   <= i_speed;
            r_rng     <= i_rng_data;
            r_remove  <= i_slot_remove;
            r_visible <= i_slot_visible;
            r_x_pos   <= i_slot_x_pos;
            r_width   <= i_slot_width;
            r_gap     <= i_slot_gap;

            case (r_state)
                c_IDLE: begin
                    if (r_start) begin
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (r_crash) begin
                        r_state <= c_HALT;
                    end else if (r_update) begin
                        r_state <= c_SPAWN;
                    end
                end
                c_SPAWN: begin
                    if (r_crash) begin
                        r_state <= c_HALT;
                    end else begin
                        r_state <= c_SETTLE;
                        if (w_spawn) begin
                            r_type_arr[r_back]   <= w_pick_type;
                            r_slot_start[r_back] <= 1'b1;
                            r_back               <= incr(r_back);
                            r_count              <= r_count + (IW+1)'(1);
                        end
                    end
                end
                c_SETTLE: begin
                    if (r_crash) begin
                        r_state <= c_HALT;
                    end else begin
                        r_state   <= c_RETIRE;
                        r_retired <= '0;
                    end
                end
                c_RETIRE: begin
                    if (r_crash) begin
                        r_state <= c_HALT;
                    end else begin
                        if (w_retire) begin
                            r_slot_start[r_front] <= 1'b0;
                            r_type_arr[r_front]   <= TW'(c_TYPE_NONE);
                            r_front               <= incr(r_front);
                            r_count               <= r_count - (IW+1)'(1);
                            r_retired             <= r_retired + RW'(1);
                        end
                        if (!w_retire || w_retire_last) begin
                            r_state <= c_RUN;
                        end
                    end
                end
                c_HALT: begin
                    if (r_start) begin
                        r_state      <= c_RUN;
                        r_front      <= '0;
                        r_back       <= '0;
                        r_count      <= '0;
                        r_slot_start <= '0;
                        for (int s = 0; s < SLOTS; s++) begin
                            r_type_arr[s] <= TW'(c_TYPE_NONE);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spawn_scheduler
//  Brief    : Self-checking bench: vector table, corner sequences and random
//             frames against a queue-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_spawn_scheduler;

    localparam int SLOTS = 7;
    localparam int TC    = 3;
    localparam int MDUP  = 2;
    localparam int RMAX  = 2;
    localparam int GW    = 640;
    localparam int SW    = 15;
    localparam int IW    = 3;
    localparam int TW    = 2;
    localparam int SPMAX = 32767;

    logic                 clk = 1'b0;
    logic                 rst, update, start, crash, enable;
    logic [SW-1:0]        speed;
    logic [10:0]          rng;
    logic [SLOTS-1:0]     remove, visible;
    logic [SLOTS*11-1:0]  xpos;
    logic [SLOTS*10-1:0]  width;
    logic [SLOTS*11-1:0]  gap;
    logic                 slot_update, full, frame_done;
    logic [SLOTS-1:0]     slot_start;
    logic [SLOTS*TW-1:0]  slot_type;
    logic [IW-1:0]        front_idx;
    logic [IW:0]          count;

    int bx [SLOTS];
    int bw [SLOTS];
    int bg [SLOTS];

    int n_checks = 0;
    int n_pass   = 0;

    int mq [$];
    int mfront;

    spawn_scheduler #(
        .SLOTS(SLOTS), .TYPE_COUNT(TC), .MAX_DUP(MDUP), .RETIRE_MAX(RMAX),
        .GAME_WIDTH(GW), .SPEED_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .i_update(update), .i_start(start), .i_crash(crash),
        .i_enable(enable), .i_speed(speed), .i_rng_data(rng),
        .i_slot_remove(remove), .i_slot_visible(visible), .i_slot_x_pos(xpos),
        .i_slot_width(width), .i_slot_gap(gap), .o_slot_update(slot_update),
        .o_slot_start(slot_start), .o_slot_type(slot_type), .o_front_idx(front_idx),
        .o_count(count), .o_full(full), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic apply_slots();
        for (int s = 0; s < SLOTS; s++) begin
            xpos[s*11 +: 11]  = 11'(bx[s]);
            width[s*10 +: 10] = 10'(bw[s]);
            gap[s*11 +: 11]   = 11'(bg[s]);
        end
    endtask

    task automatic set_geom(input int x, input int w, input int g);
        for (int s = 0; s < SLOTS; s++) begin
            bx[s] = x; bw[s] = w; bg[s] = g;
        end
        apply_slots();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; update = 1'b0; start = 1'b0; crash = 1'b0; enable = 1'b0;
        speed = '0; rng = '0; remove = '0; visible = '0;
        set_geom(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        mfront = 0;
        @(negedge clk);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        mq.delete();
        mfront = 0;
    endtask

    // One update tick, then watch a bounded window for the frame's pulses
    task automatic frame(output int un, output int ua, output int dn, output int da);
        @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
        un = 0; ua = -1; dn = 0; da = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (slot_update) begin un++; if (ua < 0) ua = j; end
            if (frame_done)  begin dn++; if (da < 0) da = j; end
        end
    endtask

    function automatic int model_pick();
        int cand, n;
        bit dup;
        n = mq.size();
        for (int i = 0; i < TC; i++) begin
            cand = ((int'(rng) + i) % TC) + 1;
            dup  = (n >= MDUP);
            for (int k = 1; k <= MDUP && dup; k++) begin
                if (mq[n-k] != cand) dup = 1'b0;
            end
            if (!dup && int'(speed) >= cand * 64) return cand;
        end
        return 0;
    endfunction

    task automatic model_frame(output int nret);
        int n, last, t;
        bit ok;
        n = mq.size();
        if (n < SLOTS && enable) begin
            if (n == 0) ok = 1'b1;
            else begin
                last = (mfront + n - 1) % SLOTS;
                ok = visible[last] && (bx[last] + bw[last] + bg[last] < GW);
            end
            t = model_pick();
            if (ok && t != 0) mq.push_back(t);
        end
        nret = 0;
        while (nret < RMAX && mq.size() > 0 && remove[mfront]) begin
            void'(mq.pop_front());
            mfront = (mfront + 1) % SLOTS;
            nret++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [SLOTS-1:0]    es;
        logic [SLOTS*TW-1:0] et;
        int idx;
        es = '0; et = '0;
        for (int j = 0; j < mq.size(); j++) begin
            idx = (mfront + j) % SLOTS;
            es[idx] = 1'b1;
            et[idx*TW +: TW] = TW'(mq[j]);
        end
        check({tag, "_count"}, int'(count), mq.size());
        check({tag, "_front"}, int'(front_idx), mfront);
        check({tag, "_full"},  int'(full), (mq.size() == SLOTS) ? 1 : 0);
        check({tag, "_start"}, int'(slot_start), int'(es));
        check({tag, "_types"}, int'(slot_type), int'(et));
    endtask

    task automatic checked_frame(input string tag);
        int nr, un, ua, dn, da;
        model_frame(nr);
        frame(un, ua, dn, da);
        check({tag, "_upd_n"},   un, 1);
        check({tag, "_upd_at"},  ua, 1);
        check({tag, "_done_n"},  dn, 1);
        check({tag, "_done_at"}, da, 3 + ((nr == RMAX) ? RMAX - 1 : nr));
        check_model(tag);
    endtask

    typedef struct {
        int x; int w; int g; bit en; bit vis; int rn; int spd; int exp_cnt; int exp_t1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int un, ua, dn, da;

        tbl[0] = '{400, 100, 140, 1, 1, 0,    SPMAX, 1, 0};
        tbl[1] = '{400, 100, 139, 1, 1, 0,    SPMAX, 2, 1};
        tbl[2] = '{-20, 300, 359, 1, 1, 1,    SPMAX, 2, 2};
        tbl[3] = '{-20, 300, 360, 1, 1, 1,    SPMAX, 1, 0};
        tbl[4] = '{-500, 100, 100, 1, 1, 5,   SPMAX, 2, 3};
        tbl[5] = '{0,   0,   0,   0, 1, 0,    SPMAX, 1, 0};
        tbl[6] = '{0,   0,   0,   1, 0, 0,    SPMAX, 1, 0};
        tbl[7] = '{0,   0,   0,   1, 1, 0,    10,    1, 0};
        tbl[8] = '{0,   0,   0,   1, 1, 1,    100,   2, 1};
        tbl[9] = '{0,   0,   0,   1, 1, 2047, SPMAX, 2, 2};

        // Reset values and IDLE ignoring update
        do_reset();
        check("rst_count", int'(count), 0);
        check("rst_start", int'(slot_start), 0);
        check("rst_types", int'(slot_type), 0);
        check("rst_front", int'(front_idx), 0);
        check("rst_pulses", int'({slot_update, full, frame_done}), 0);
        enable = 1'b1; speed = SW'(SPMAX);
        frame(un, ua, dn, da);
        check("idle_upd_n", un, 0);
        check("idle_done_n", dn, 0);

        // First spawn latency
        do_start();
        checked_frame("first");
        check("first_start0", int'(slot_start[0]), 1);

        // Vector table: each starts from one live type-1 object in slot 0
        for (int v = 0; v < 10; v++) begin
            do_reset();
            do_start();
            enable = 1'b1; visible = '1; speed = SW'(SPMAX); rng = '0;
            frame(un, ua, dn, da);
            check($sformatf("vec%0d_seed", v), int'(slot_type[1:0]), 1);
            bx[0] = tbl[v].x; bw[0] = tbl[v].w; bg[0] = tbl[v].g;
            apply_slots();
            enable = tbl[v].en; visible[0] = tbl[v].vis;
            rng = 11'(tbl[v].rn); speed = SW'(tbl[v].spd);
            frame(un, ua, dn, da);
            check($sformatf("vec%0d_count", v), int'(count), tbl[v].exp_cnt);
            check($sformatf("vec%0d_type1", v), int'(slot_type[3:2]), tbl[v].exp_t1);
        end

        // Fill to full, then one more frame
        do_reset();
        do_start();
        enable = 1'b1; visible = '1; speed = SW'(SPMAX);
        for (int i = 0; i < SLOTS + 1; i++) begin
            rng = 11'($urandom_range(0, 2047));
            checked_frame($sformatf("fill%0d", i));
            check($sformatf("fill%0d_cnt", i), int'(count), (i < SLOTS) ? i + 1 : SLOTS);
        end
        check("fill_full", int'(full), 1);

        // Duplicate-run limit, then speed gating
        do_reset();
        do_start();
        enable = 1'b1; visible = '1; speed = SW'(SPMAX); rng = '0;
        repeat (3) checked_frame("dup");
        check("dup_t0", int'(slot_type[1:0]), 1);
        check("dup_t1", int'(slot_type[3:2]), 1);
        check("dup_t2", int'(slot_type[5:4]), 2);
        speed = SW'(10);
        checked_frame("slow");
        check("slow_count", int'(count), 3);

        // Retire limit and front wrap 6 -> 0
        do_reset();
        do_start();
        enable = 1'b1; visible = '1; speed = SW'(SPMAX); rng = '0;
        repeat (SLOTS) checked_frame("rfill");
        enable = 1'b0; remove = 7'b0011111;
        repeat (3) checked_frame("ret");
        check("ret_front5", int'(front_idx), 5);
        remove = '0; enable = 1'b1;
        checked_frame("respawn");
        enable = 1'b0; remove = 7'b1100001;
        checked_frame("wrap");
        check("wrap_front", int'(front_idx), 0);
        check("wrap_count", int'(count), 1);
        checked_frame("wrap2");
        check("wrap2_count", int'(count), 0);
        remove = '0;

        // crash with update, HALT, restart
        do_reset();
        do_start();
        enable = 1'b1; visible = '1; speed = SW'(SPMAX); rng = '0;
        repeat (2) checked_frame("pre");
        @(posedge clk); #1 crash = 1'b1; update = 1'b1;
        @(posedge clk); #1 crash = 1'b0; update = 1'b0;
        un = 0; dn = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (slot_update) un++;
            if (frame_done)  dn++;
        end
        check("crash_upd_n", un, 0);
        check("crash_done_n", dn, 0);
        frame(un, ua, dn, da);
        check("halt_upd_n", un, 0);
        check("halt_count", int'(count), 2);
        do_start();
        check_model("restart");
        checked_frame("post");

        // crash inside the frame suppresses frame_done
        @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0; crash = 1'b1;
        @(posedge clk); #1 crash = 1'b0;
        dn = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (frame_done) dn++;
        end
        check("abort_done_n", dn, 0);

        // rst mid-frame: no pulses afterwards
        do_start();
        @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        un = 0; dn = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (slot_update) un++;
            if (frame_done)  dn++;
        end
        check("rstmid_pulses", un + dn, 0);
        check("rstmid_count", int'(count), 0);

        // Random frames against the reference model
        do_reset();
        do_start();
        for (int f = 0; f < 60; f++) begin
            enable = ($urandom_range(0, 9) != 0);
            rng = 11'($urandom_range(0, 2047));
            case ($urandom_range(0, 4))
                0: speed = SW'(10);
                1: speed = SW'(100);
                2: speed = SW'(150);
                3: speed = SW'(200);
                default: speed = SW'(SPMAX);
            endcase
            for (int s = 0; s < SLOTS; s++) begin
                remove[s]  = ($urandom_range(0, 9) < 3);
                visible[s] = ($urandom_range(0, 19) < 17);
                bx[s] = int'($urandom_range(0, 800)) - 100;
                bw[s] = int'($urandom_range(0, 200));
                bg[s] = int'($urandom_range(0, 300));
            end
            apply_slots();
            checked_frame($sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
